// File: rtl/pipeline_flow_ctrl.sv
// pipeline_flow_ctrl: stall/flush/halt and debug run/step sequencing for a 5-stage MIPS pipeline.
// Optional perf counters (o_stall_cnt, o_flush_cnt) are built when PIPE_PERF_CNT_EN is defined.
module pipeline_flow_ctrl #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_stall,
  input  logic             i_flush_if_id,
  input  logic             i_flush_id_ex,
  input  logic             i_halt,
  input  logic             i_run,
  input  logic             i_step,
  input  logic             i_resume,
  output logic             o_pc_we,
  output logic             o_if_id_we,
  output logic             o_if_id_flush,
  output logic             o_id_ex_flush,
  output logic             o_stage_en,
  output logic             o_halted,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_cycle_cnt,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
);
  typedef enum logic [2:0] {IDLE, RUN, STEP, DRAIN, HALTED} state_t;
  state_t           r_state, w_next;
  logic [3:0]       r_drain, w_drain_nxt;
  logic [CNT_W-1:0] r_cycle_cnt;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_drain     <= '0;
      r_cycle_cnt <= '0;
    end else begin
      r_state     <= w_next;
      r_drain     <= w_drain_nxt;
      r_cycle_cnt <= (o_stage_en && r_cycle_cnt != '1) ? r_cycle_cnt + 1'b1 : r_cycle_cnt;
    end
  always_comb begin
    w_next        = r_state;
    w_drain_nxt   = r_drain;
    o_pc_we       = 1'b0;
    o_if_id_we    = 1'b0;
    o_if_id_flush = 1'b0;
    o_id_ex_flush = 1'b0;
    o_stage_en    = 1'b0;
    o_halted      = 1'b0;
    o_busy        = r_state == RUN || r_state == STEP || r_state == DRAIN;
    case (r_state)
      IDLE: w_next = i_run ? RUN : i_step ? STEP : IDLE;
      RUN, STEP: begin
        o_stage_en = 1'b1;
        if (i_halt) begin
          o_id_ex_flush = 1'b1;
          w_drain_nxt   = 4'(DRAIN_CYCLES - 1);
          w_next        = (DRAIN_CYCLES == 1) ? HALTED : DRAIN;
        end else begin
          o_pc_we       = i_flush_if_id | ~i_stall;
          o_if_id_we    = i_flush_if_id | ~i_stall;
          o_if_id_flush = i_flush_if_id;
          o_id_ex_flush = (i_stall & ~i_flush_if_id) | i_flush_id_ex;
          w_next        = (r_state == RUN && i_run) ? RUN : IDLE;
        end
      end
      DRAIN: begin
        o_stage_en    = 1'b1;
        o_id_ex_flush = 1'b1;
        w_drain_nxt   = r_drain - 4'd1;
        w_next        = (r_drain <= 4'd1) ? HALTED : DRAIN;
      end
      HALTED: begin
        o_halted = 1'b1;
        w_next   = i_resume ? IDLE : HALTED;
      end
      default: w_next = IDLE;
    endcase
  end
  assign o_cycle_cnt = r_cycle_cnt;
`ifdef PIPE_PERF_CNT_EN
  logic             w_adv, w_case_b, w_case_c;
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;
  assign w_adv    = (r_state == RUN || r_state == STEP) && !i_halt;
  assign w_case_b = w_adv && i_flush_if_id;
  assign w_case_c = w_adv && !i_flush_if_id && i_stall;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_stall_cnt <= (w_case_c && r_stall_cnt != '1) ? r_stall_cnt + 1'b1 : r_stall_cnt;
      r_flush_cnt <= (w_case_b && r_flush_cnt != '1) ? r_flush_cnt + 1'b1 : r_flush_cnt;
    end
  assign o_stall_cnt = r_stall_cnt;
  assign o_flush_cnt = r_flush_cnt;
`else
  assign o_stall_cnt = '0;
  assign o_flush_cnt = '0;
`endif
endmodule

// File: tb/tb_pipeline_flow_ctrl.sv
// tb_pipeline_flow_ctrl: directed vectors with a queue scoreboard for pipeline_flow_ctrl.
module tb_pipeline_flow_ctrl;
  localparam int CW = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0, run = 1'b1, step = 1'b0, stall = 1'b0, fif = 1'b0, fie = 1'b0, halt = 1'b0, resume = 1'b0;
  logic pc_we, if_id_we, if_id_flush, id_ex_flush, stage_en, halted, busy;
  logic [CW-1:0] cyc_cnt, st_cnt, fl_cnt;
  typedef struct packed {
    logic [6:0]    o;
    logic [CW-1:0] c;
    logic [CW-1:0] s;
    logic [CW-1:0] f;
  } exp_t;
  exp_t  exp_q[$];
  string nm_q[$];
  int n_chk = 0, n_fail = 0;
  logic [CW-1:0] e_cyc = '0, e_st = '0, e_fl = '0;
  always #5 clk = ~clk;
  pipeline_flow_ctrl #(.DRAIN_CYCLES(3), .CNT_W(CW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_stall(stall), .i_flush_if_id(fif), .i_flush_id_ex(fie),
    .i_halt(halt), .i_run(run), .i_step(step), .i_resume(resume),
    .o_pc_we(pc_we), .o_if_id_we(if_id_we), .o_if_id_flush(if_id_flush), .o_id_ex_flush(id_ex_flush),
    .o_stage_en(stage_en), .o_halted(halted), .o_busy(busy),
    .o_cycle_cnt(cyc_cnt), .o_stall_cnt(st_cnt), .o_flush_cnt(fl_cnt)
  );
  // in = {rst_n, run, step, stall, fif, fie, halt, resume}
  // eo = {pc_we, if_id_we, if_id_flush, id_ex_flush, stage_en, halted, busy}
  task automatic cyc(input logic [7:0] in, input logic [6:0] eo, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    {rst_n, run, step, stall, fif, fie, halt, resume} = in;
    if (!in[7]) begin
      e_cyc = '0;
      e_st  = '0;
      e_fl  = '0;
    end
    e.o = eo;
    e.c = e_cyc;
`ifdef PIPE_PERF_CNT_EN
    e.s = e_st;
    e.f = e_fl;
`else
    e.s = '0;
    e.f = '0;
`endif
    exp_q.push_back(e);
    nm_q.push_back(nm);
    if (eo[2] && e_cyc != '1) e_cyc = e_cyc + 1'b1;
    if (eo[4] && e_fl != '1) e_fl = e_fl + 1'b1;
    if (in[4] && !in[3] && !in[1] && eo[2] && !eo[6] && e_st != '1) e_st = e_st + 1'b1;
  endtask
  always @(negedge clk)
    if (exp_q.size() > 0) begin
      exp_t  e;
      exp_t  a;
      string n;
      e = exp_q.pop_front();
      n = nm_q.pop_front();
      a = {pc_we, if_id_we, if_id_flush, id_ex_flush, stage_en, halted, busy, cyc_cnt, st_cnt, fl_cnt};
      n_chk++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL %s: got o=%b cyc=%0d st=%0d fl=%0d, want o=%b cyc=%0d st=%0d fl=%0d",
                 n, a.o, a.c, a.s, a.f, e.o, e.c, e.s, e.f);
      end
    end
  initial begin
    cyc(8'b0100_0000, 7'b0000000, "reset_run");
    cyc(8'b0100_0000, 7'b0000000, "reset_hold");
    cyc(8'b1100_0000, 7'b0000000, "release_idle");
    cyc(8'b1100_0000, 7'b1100101, "run_adv");
    cyc(8'b1101_0000, 7'b0001101, "run_stall");
    cyc(8'b1100_0000, 7'b1100101, "after_stall");
    cyc(8'b1101_1000, 7'b1110101, "flush_stall");
    cyc(8'b1101_1100, 7'b1111101, "flush_stall_fie");
    cyc(8'b1100_0100, 7'b1101101, "fie_only");
    cyc(8'b1110_0000, 7'b1100101, "run_step_ign");
    cyc(8'b1100_0010, 7'b0001101, "halt_detect");
    cyc(8'b1101_1110, 7'b0001101, "drain1");
    cyc(8'b1100_0010, 7'b0001101, "drain2");
    cyc(8'b1110_0010, 7'b0000010, "halted");
    cyc(8'b1110_0010, 7'b0000010, "halted_ign");
    cyc(8'b1000_0001, 7'b0000010, "resume");
    cyc(8'b1000_0000, 7'b0000000, "idle");
    cyc(8'b1000_0010, 7'b0000000, "idle_halt_ign");
    for (int i = 0; i < 4; i++) begin
      cyc(8'b1010_0000, 7'b0000000, "step_req");
      cyc(8'b1000_0000, 7'b1100101, "step_adv");
      cyc(8'b1000_0000, 7'b0000000, "step_idle");
    end
    cyc(8'b1110_0000, 7'b0000000, "run_wins");
    cyc(8'b1100_0000, 7'b1100101, "run_state");
    cyc(8'b1000_0000, 7'b1100101, "run_drop");
    cyc(8'b1000_0000, 7'b0000000, "back_idle");
    cyc(8'b1010_0000, 7'b0000000, "step_req2");
    cyc(8'b1000_0010, 7'b0001101, "step_halt");
    cyc(8'b1000_0000, 7'b0001101, "step_drain1");
    cyc(8'b0000_0000, 7'b0000000, "rst_mid_drain");
    cyc(8'b1000_0000, 7'b0000000, "post_rst_idle");
    cyc(8'b1000_0000, 7'b0000000, "post_rst_idle2");
    repeat (3) @(negedge clk);
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_queue: got %0d pending, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pipeline_flow_ctrl.md
Name: pipeline_flow_ctrl

Overview:
- Consumes the stall, flush and halt requests from hazard detection and turns them into per-stage write enables and flushes for the 5-stage MIPS pipeline.
- Sequences debug run and single-step control from the debug unit.
- On HALT it drains the older instructions through EX/MEM/WB, then freezes the pipeline and reports halted.
- Sits between hazard detection, the debug unit and the PC and pipeline registers.

Parameters:
DRAIN_CYCLES, 3, enabled cycles after HALT detection, counting the detection cycle; legal range 1..15.
CNT_W, 32, width of the cycle counter and of the optional perf counters.

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  asynchronous active-low reset
i_stall  in  1  load-use stall request from hazard detection
i_flush_if_id  in  1  branch/jump taken; flush IF/ID
i_flush_id_ex  in  1  bubble request for ID/EX
i_halt  in  1  HALT decoded in ID
i_run  in  1  debug level: continuous run
i_step  in  1  debug pulse: advance exactly one cycle
i_resume  in  1  debug pulse: leave HALTED
o_pc_we  out  1  PC write enable
o_if_id_we  out  1  IF/ID write enable
o_if_id_flush  out  1  IF/ID synchronous clear
o_id_ex_flush  out  1  ID/EX synchronous clear (bubble)
o_stage_en  out  1  enable for ID/EX, EX/MEM and MEM/WB registers and for register-file/memory writes
o_halted  out  1  pipeline frozen after drain
o_busy  out  1  state is RUN, STEP or DRAIN
o_cycle_cnt  out  CNT_W  cycles with o_stage_en=1; saturates at all-ones
o_stall_cnt  out  CNT_W  optional, see below
o_flush_cnt  out  CNT_W  optional, see below

Behaviour:
- States: IDLE, RUN, STEP, DRAIN, HALTED. The state, drain counter and all counters are registered.
- Outputs are combinational from state and inputs (Mealy), so a hazard takes effect in the cycle it is raised.
- Reset (async, i_rst_n=0): state=IDLE, counters=0. All outputs are 0, which is the IDLE decode.
- IDLE: all enables and flushes 0.
  - i_halt has no effect in IDLE.
  - i_run=1 -> RUN.
  - Otherwise i_step=1 -> STEP.
  - If i_run and i_step are both high, i_run wins.
- Advance decode, used in RUN and STEP, in priority order:
  - (a) i_halt=1: pc_we=0, if_id_we=0, id_ex_flush=1, stage_en=1, if_id_flush=0. Load drain counter with DRAIN_CYCLES-1. Next state is DRAIN, or HALTED if DRAIN_CYCLES=1.
  - (b) i_flush_if_id=1: pc_we=1, if_id_we=1, if_id_flush=1, id_ex_flush=i_flush_id_ex, stage_en=1. i_stall is ignored.
  - (c) i_stall=1: pc_we=0, if_id_we=0, id_ex_flush=1, stage_en=1.
  - (d) no request: pc_we=1, if_id_we=1, id_ex_flush=i_flush_id_ex, stage_en=1.
- RUN:
  - Advance decode every cycle. i_step is ignored.
  - i_run=0 with no halt -> IDLE at the next edge; that cycle still advances.
- STEP:
  - Exactly one cycle of advance decode.
  - Returns to IDLE unless case (a) fires, which moves to DRAIN.
  - A drain started from STEP completes autonomously.
- DRAIN:
  - pc_we=0, if_id_we=0, if_id_flush=0, id_ex_flush=1, stage_en=1.
  - i_stall, i_flush_*, i_halt, i_run and i_step are ignored.
  - Counter decrements each cycle; when it is 1 the next state is HALTED.
  - stage_en is therefore high for exactly DRAIN_CYCLES cycles, counting the detection cycle.
- HALTED:
  - All enables 0; o_halted=1.
  - i_resume=1 -> IDLE.
  - i_run and i_step are ignored until resumed.
- o_cycle_cnt increments on every cycle with o_stage_en=1 and saturates at all-ones. It is not cleared by i_resume.
- Reset mid-DRAIN or mid-STEP returns to IDLE immediately; no drain completion.

Optional Feature:
PIPE_PERF_CNT_EN
- Defined:
  - o_stall_cnt counts advance cycles taking case (c).
  - o_flush_cnt counts advance cycles taking case (b).
  - Both saturate, and both reset to 0 on i_rst_n.
- Undefined: both ports are tied to 0 and no counter flops are built.

Test Plan:
- Reset with i_run=1 and i_rst_n=0 -> all outputs 0. Release reset -> next cycle state RUN, pc_we=1, if_id_we=1, stage_en=1.
- RUN, i_stall pulsed high for 1 cycle -> that cycle pc_we=0, if_id_we=0, id_ex_flush=1, stage_en=1. Following cycle pc_we=1. o_stall_cnt=1 if PIPE_PERF_CNT_EN.
- RUN, i_flush_if_id=1 and i_stall=1 together -> pc_we=1, if_id_flush=1, id_ex_flush follows i_flush_id_ex. o_flush_cnt=1, o_stall_cnt unchanged.
- RUN, DRAIN_CYCLES=3, i_halt held high -> stage_en=1 for exactly 3 cycles with pc_we=0, then o_halted=1 and o_busy=0. i_resume pulse -> IDLE, o_halted=0.
- IDLE, i_run=0: i_step pulsed 4 times, 2 idle cycles apart -> 4 single-cycle stage_en pulses; o_cycle_cnt goes from 0 to 4.
- DRAIN, second cycle: assert i_rst_n=0 -> outputs 0 asynchronously. After release with i_run=0 -> IDLE, o_halted=0, o_cycle_cnt=0.
